// File: rtl/pipe_pkg.sv
// pipe_pkg: shared data-memory defaults and access FSM state encoding
package pipe_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} dmem_state_e;
endpackage

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr: saturating 8-bit wait counter with terminal count at TIMEOUT-1
module dmem_wait_ctr import pipe_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 8'd0 : (en_i && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
  assign tc_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory handshake FSM with stall, timeout and branch resolve
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit import pipe_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [ADDR_W-1:0] MEM_ALUresult,
  input  logic [DATA_W-1:0] MEM_MemData,
  input  logic              MEM_Branch,
  input  logic              MEM_zero,
  input  logic [63:0]       MEM_PCadd,
  output logic              PCSrc,
  output logic [63:0]       BranchTarget,
  output logic              stall,
  output logic [DATA_W-1:0] MEM_ReadData,
  output logic              rdata_valid,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              bus_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  input  logic [DATA_W-1:0] dm_rdata
);
  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, mis_q, mis_d, tc, access, misal;
  assign access = MEM_MemRead | MEM_MemWrite;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = MEM_ALUresult[2:0] != 3'b0;
  assign misalign = state_q == ERR && mis_q;
`else
  assign misal = 1'b0;
`endif
  dmem_wait_ctr #(.TIMEOUT(TIMEOUT)) u_wait_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == IDLE),
    .en_i (state_q == REQ),
    .tc_o (tc)
  );
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    stall       = 1'b0;
    dm_req      = 1'b0;
    rdata_valid = 1'b0;
    bus_err     = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        stall   = 1'b1;
        mis_d   = misal;
        state_d = misal ? ERR : REQ;
        rdata_d = misal ? '0 : rdata_q;
        addr_d  = misal ? addr_q : MEM_ALUresult;
        we_d    = misal ? we_q : MEM_MemWrite;
        wdata_d = misal ? wdata_q : MEM_MemData;
      end
      REQ: begin
        stall   = 1'b1;
        dm_req  = 1'b1;
        // a ready on the terminal-count cycle still completes the transfer
        state_d = dm_ready ? DONE : tc ? ERR : REQ;
        rdata_d = (dm_ready && !we_q) ? dm_rdata : (!dm_ready && tc) ? '0 : rdata_q;
      end
      DONE: begin
        rdata_valid = !we_q;
        state_d     = IDLE;
      end
      default: begin
        bus_err = !mis_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end
  assign dm_addr      = addr_q;
  assign dm_we        = we_q;
  assign dm_wdata     = wdata_q;
  assign MEM_ReadData = rdata_q;
  assign PCSrc        = MEM_Branch & MEM_zero & ~stall;
  assign BranchTarget = MEM_PCadd;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed accesses with a completion scoreboard checked by a negedge monitor
module tb_dmem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0, MEM_Branch = 1'b0, MEM_zero = 1'b0;
  logic [63:0] MEM_ALUresult = '0, MEM_MemData = '0, MEM_PCadd = '0;
  logic        PCSrc, stall, rdata_valid, bus_err, dm_req, dm_we, mis_o;
  logic [63:0] BranchTarget, MEM_ReadData, dm_addr, dm_wdata;
  logic        dm_ready = 1'b0;
  logic [63:0] dm_rdata = '0;
  int checks = 0, errors = 0;

  typedef struct {
    logic        we;
    logic [63:0] addr, wdata, rdata;
    int          slen, rcnt;
    logic        rv, be, mis;
  } exp_t;
  exp_t sb[$];

  dmem_access_unit dut (
    .clk(clk), .rst(rst),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_ALUresult(MEM_ALUresult), .MEM_MemData(MEM_MemData),
    .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero), .MEM_PCadd(MEM_PCadd),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .stall(stall),
    .MEM_ReadData(MEM_ReadData), .rdata_valid(rdata_valid),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign(mis_o),
`endif
    .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata)
  );
`ifndef DMEM_MISALIGN_TRAP_EN
  assign mis_o = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [63:0] addr, wdata, rdata,
                      input int slen, rcnt, input logic rv, be, mis);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.slen = slen; e.rcnt = rcnt; e.rv = rv; e.be = be; e.mis = mis;
    sb.push_back(e);
  endtask

  // ready_at: REQ cycle (1-based) on which dm_ready is raised, 0 = never
  task automatic access(input logic rd, wr, input logic [63:0] addr, wdata,
                        input int ready_at, input logic [63:0] rdata, input logic trap);
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_ALUresult = addr; MEM_MemData = wdata;
    #1 chk("pcsrc_gated_by_stall", PCSrc, 0);
    cyc();
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    if (!trap)
      for (int k = 1; k <= 16; k++) begin
        dm_ready = (k == ready_at);
        dm_rdata = rdata;
        cyc();
        if (k == ready_at) break;
      end
    dm_ready = 1'b0;
    cyc();
  endtask

  logic prev_stall = 1'b0;
  int   slen = 0, rcnt = 0;
  always @(negedge clk) begin
    if (stall) begin
      slen++;
      if (dm_req) begin
        rcnt++;
        if (sb.size() == 0) chk("req_without_expect", 1, 0);
        else begin
          chk("dm_addr", dm_addr, sb[0].addr);
          chk("dm_we", {63'd0, dm_we}, {63'd0, sb[0].we});
          chk("dm_wdata", dm_wdata, sb[0].wdata);
        end
      end
    end else if (prev_stall) begin
      if (sb.size() == 0) chk("completion_without_expect", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata_valid", {63'd0, rdata_valid}, {63'd0, e.rv});
        chk("bus_err", {63'd0, bus_err}, {63'd0, e.be});
        chk("misalign", {63'd0, mis_o}, {63'd0, e.mis});
        chk("MEM_ReadData", MEM_ReadData, e.rdata);
        chk("dm_req_after", {63'd0, dm_req}, 0);
        chk("stall_cycles", 64'(slen), 64'(e.slen));
        chk("req_cycles", 64'(rcnt), 64'(e.rcnt));
      end
      slen = 0;
      rcnt = 0;
    end else if (!rst) chk("idle_strobes", {61'd0, rdata_valid, bus_err, mis_o}, 0);
    prev_stall = stall;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_stall", {63'd0, stall}, 0);
    chk("rst_dm_req", {63'd0, dm_req}, 0);
    chk("rst_rdata_valid", {63'd0, rdata_valid}, 0);
    chk("rst_bus_err", {63'd0, bus_err}, 0);
    chk("rst_ReadData", MEM_ReadData, 0);
    chk("rst_dm_addr", dm_addr, 0);
    MEM_Branch = 1'b1; MEM_zero = 1'b1; MEM_PCadd = 64'h100;
    #1 chk("branch_pcsrc", {63'd0, PCSrc}, 1);
    chk("branch_target", BranchTarget, 64'h100);
    chk("branch_no_stall", {63'd0, stall}, 0);
    MEM_zero = 1'b0;
    #1 chk("branch_not_taken", {63'd0, PCSrc}, 0);
    MEM_zero = 1'b1;
    cyc();
    push(0, 64'h40, 0, 64'hDEADBEEF, 2, 1, 1, 0, 0);
    access(1, 0, 64'h40, 0, 1, 64'hDEADBEEF, 0);
    MEM_Branch = 1'b0; MEM_zero = 1'b0;
    push(1, 64'h80, 64'h1234, 64'hDEADBEEF, 6, 5, 0, 0, 0);
    access(0, 1, 64'h80, 64'h1234, 5, 64'hBAD, 0);
    push(1, 64'h88, 64'h55, 64'hDEADBEEF, 2, 1, 0, 0, 0);
    access(1, 1, 64'h88, 64'h55, 1, 64'hBAD, 0);
    push(0, 64'h48, 0, 64'h0, 17, 16, 0, 1, 0);
    access(1, 0, 64'h48, 0, 0, 64'hBAD, 0);
    push(0, 64'h60, 0, 64'hCAFE, 17, 16, 1, 0, 0);
    access(1, 0, 64'h60, 0, 16, 64'hCAFE, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    push(0, 64'h43, 0, 64'h0, 1, 0, 0, 0, 1);
    access(1, 0, 64'h43, 0, 0, 64'h0, 1);
`else
    push(0, 64'h43, 0, 64'h77, 2, 1, 1, 0, 0);
    access(1, 0, 64'h43, 0, 1, 64'h77, 0);
`endif
    push(0, 64'h50, 0, 64'h0, 3, 2, 0, 0, 0);
    MEM_MemRead = 1'b1; MEM_ALUresult = 64'h50;
    cyc();
    MEM_MemRead = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 chk("abandon_stall", {63'd0, stall}, 0);
    chk("abandon_dm_req", {63'd0, dm_req}, 0);
    repeat (3) cyc();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning data-address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data-word width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning max REQ cycles awaiting dm_ready (range 1..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have MEM_MemRead  in  1  load in MEM stage; MEM_MemWrite  in  1  store in MEM stage.
REQ-006 SHALL have MEM_ALUresult  in  ADDR_W  byte address; MEM_MemData  in  DATA_W  store data.
REQ-007 SHALL have MEM_Branch  in  1; MEM_zero  in  1; MEM_PCadd  in  64  branch target.
REQ-008 SHALL have PCSrc  out  1  take branch; BranchTarget  out  64  = MEM_PCadd.
REQ-009 SHALL have stall  out  1  freeze IF..EX/MEM; MEM_ReadData  out  DATA_W  load result; rdata_valid  out  1  one-cycle load-done strobe; bus_err  out  1  one-cycle timeout strobe.
REQ-010 SHALL have dm_req  out  1; dm_we  out  1; dm_addr  out  ADDR_W; dm_wdata  out  DATA_W; dm_ready  in  1; dm_rdata  in  DATA_W.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, DONE, ERR.
REQ-012 IDLE: if MEM_MemRead|MEM_MemWrite, stall=1 combinationally same cycle, next state REQ; else stay IDLE, stall=0.
REQ-013 MEM_MemRead and MEM_MemWrite both high SHALL be handled as a write; read ignored.
REQ-014 On IDLE->REQ edge, address, we and wdata SHALL be latched; dm_addr/dm_we/dm_wdata SHALL hold these stable throughout REQ.
REQ-015 REQ: dm_req=1, stall=1; wait counter increments each REQ cycle.
REQ-016 REQ with dm_ready=1: transfer completes; for read, dm_rdata captured into MEM_ReadData; next state DONE; dm_req deasserts next cycle.
REQ-017 REQ with counter==TIMEOUT-1 and dm_ready=0: next state ERR; dm_ready on that same cycle wins over timeout.
REQ-018 DONE: stall=0, dm_req=0, rdata_valid=1 for read (0 for write), next state IDLE unconditionally.
REQ-019 ERR: stall=0, bus_err=1, MEM_ReadData=0, next state IDLE.
REQ-020 Minimum access latency SHALL be 3 cycles (IDLE, REQ with ready, DONE); stall high for exactly 2 cycles in that case.
REQ-021 MEM_ReadData SHALL hold its value until next completed read, ERR, or reset.
REQ-022 PCSrc SHALL equal MEM_Branch & MEM_zero & ~stall, combinational; BranchTarget = MEM_PCadd.
REQ-023 Wait counter SHALL be 8 bits, cleared on entry to REQ, never wraps.

Reset
REQ-024 rst high at a clk edge SHALL force IDLE, counter 0, MEM_ReadData 0, latched addr/data 0; stall, dm_req, rdata_valid, bus_err SHALL be 0 the following cycle.
REQ-025 rst during REQ SHALL abandon the access; no rdata_valid or bus_err generated for it.

Configuration
REQ-026 Macro DMEM_MISALIGN_TRAP_EN SHALL, when defined, add output misalign (1 bit): in IDLE an access with MEM_ALUresult[2:0]!=0 skips REQ, goes to ERR-equivalent path asserting misalign (not bus_err) for one cycle, dm_req never raised.
REQ-027 Without DMEM_MISALIGN_TRAP_EN, port misalign SHALL not exist and misaligned addresses SHALL be issued unchanged.

Structure
REQ-028 FSM state enum, TIMEOUT default and ADDR_W/DATA_W defaults SHALL live in shared package pipe_pkg.
REQ-029 Timeout counter SHALL be a sub-module dmem_wait_ctr (clear, enable, terminal-count output).

Verification
REQ-030 Load, addr 0x40, dm_ready at first REQ cycle, dm_rdata=0xDEADBEEF -> stall high 2 cycles, rdata_valid in cycle 3, MEM_ReadData=0xDEADBEEF.
REQ-031 Store, addr 0x80, data 0x1234, dm_ready after 5 REQ cycles -> dm_we=1, dm_addr/dm_wdata stable 5 cycles, stall 6 cycles, no rdata_valid.
REQ-032 Load with dm_ready never asserted, TIMEOUT=16 -> 16 REQ cycles, bus_err pulse 1 cycle, MEM_ReadData=0, return IDLE.
REQ-033 MEM_Branch=1, MEM_zero=1, MEM_PCadd=0x100, no memory op -> PCSrc=1, BranchTarget=0x100, stall=0.
REQ-034 rst asserted on 2nd REQ cycle of a load -> next cycle dm_req=0, stall=0, no rdata_valid.
REQ-035 With DMEM_MISALIGN_TRAP_EN, load at 0x43 -> misalign pulse, dm_req stays 0; without macro -> dm_addr=0x43 issued.
